// File: rtl/console_pkg.sv
// Shared constants, state encoding and cell addressing for the text console writer.
package console_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 25;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] PRINT_MIN  = 8'h20;
    localparam logic [7:0] CC_BS      = 8'h08;
    localparam logic [7:0] CC_LF      = 8'h0A;
    localparam logic [7:0] CC_FF      = 8'h0C;
    localparam logic [7:0] CC_CR      = 8'h0D;

    // First byte past the character cells; palette and font live from here up.
    localparam logic [12:0] PALETTE_BASE = 13'hFA0;

    typedef enum logic [2:0] {
        IDLE,
        WR_CHAR,
        WR_ATTR,
        SCR_RD,
        SCR_WR,
        FILL,
        CLEAR
    } state_t;

    // Byte address of the char half of cell (x,y); attr sits at +1.
    function automatic logic [12:0] cell_addr(input logic [7:0] x, input logic [7:0] y,
                                              input int cols);
        int lin;
        lin = 2 * (int'(x) + cols * int'(y));
        return lin[12:0];
    endfunction

endpackage

// File: rtl/text_console.sv
// Byte-stream writer for the text BRAM: prints chars at the cursor, handles CR/LF/BS/FF,
// wraps lines and scrolls/clears through the BRAM's second port.
module text_console
    import console_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter logic [7:0] BLANK = BLANK_CHAR
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    input  logic [7:0]  attr,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y,
    output logic [12:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    localparam logic [12:0] ROW_BYTES = 13'(2 * COLS);
    localparam logic [12:0] SCR_BYTES = 13'(2 * COLS * (ROWS - 1));
    localparam logic [12:0] ALL_BYTES = 13'(2 * COLS * ROWS);
    localparam logic [7:0]  X_LAST    = 8'(COLS - 1);
    localparam logic [7:0]  Y_LAST    = 8'(ROWS - 1);

    state_t      state;
    logic [12:0] cnt;
    logic [7:0]  attr_q;
    logic [7:0]  wdata_q;
    logic        bs_q;

    // Scroll copies read data straight back out the cycle it arrives.
    assign mem_wdata = (state == SCR_WR) ? mem_rdata : wdata_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= IDLE;
            cursor_x    <= '0;
            cursor_y    <= '0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            wdata_q     <= '0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            cnt         <= '0;
            attr_q      <= '0;
            bs_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        attr_q <= attr;
                        bs_q   <= 1'b0;
                        if (in_char >= PRINT_MIN) begin
                            state       <= WR_CHAR;
                            in_ready    <= 1'b0;
                            mem_we      <= 1'b1;
                            mem_address <= cell_addr(cursor_x, cursor_y, COLS);
                            wdata_q     <= in_char;
                        end else begin
                            case (in_char)
                                CC_CR: cursor_x <= '0;
                                CC_LF: begin
                                    cursor_x <= '0;
                                    if (cursor_y == Y_LAST) begin
                                        state       <= SCR_RD;
                                        in_ready    <= 1'b0;
                                        busy        <= 1'b1;
                                        cnt         <= '0;
                                        mem_address <= ROW_BYTES;
                                    end else begin
                                        cursor_y <= cursor_y + 8'd1;
                                    end
                                end
                                CC_BS: begin
                                    if (cursor_x != 8'd0) begin
                                        cursor_x    <= cursor_x - 8'd1;
                                        bs_q        <= 1'b1;
                                        state       <= WR_CHAR;
                                        in_ready    <= 1'b0;
                                        mem_we      <= 1'b1;
                                        mem_address <= cell_addr(cursor_x - 8'd1, cursor_y, COLS);
                                        wdata_q     <= BLANK;
                                    end
                                end
                                CC_FF: begin
                                    state       <= CLEAR;
                                    in_ready    <= 1'b0;
                                    busy        <= 1'b1;
                                    cnt         <= '0;
                                    mem_we      <= 1'b1;
                                    mem_address <= '0;
                                    wdata_q     <= BLANK;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                WR_CHAR: begin
                    state       <= WR_ATTR;
                    mem_address <= mem_address + 13'd1;
                    wdata_q     <= attr_q;
                end
                WR_ATTR: begin
                    mem_we   <= 1'b0;
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    // Backspace already moved the cursor before writing.
                    if (!bs_q) begin
                        if (cursor_x == X_LAST) begin
                            cursor_x <= '0;
                            if (cursor_y == Y_LAST) begin
                                state       <= SCR_RD;
                                in_ready    <= 1'b0;
                                busy        <= 1'b1;
                                cnt         <= '0;
                                mem_address <= ROW_BYTES;
                            end else begin
                                cursor_y <= cursor_y + 8'd1;
                            end
                        end else begin
                            cursor_x <= cursor_x + 8'd1;
                        end
                    end
                end
                SCR_RD: begin
                    state       <= SCR_WR;
                    mem_address <= cnt;
                    mem_we      <= 1'b1;
                end
                SCR_WR: begin
                    if (cnt == SCR_BYTES - 13'd1) begin
                        state       <= FILL;
                        cnt         <= '0;
                        mem_address <= SCR_BYTES;
                        wdata_q     <= BLANK;
                    end else begin
                        state       <= SCR_RD;
                        mem_we      <= 1'b0;
                        cnt         <= cnt + 13'd1;
                        mem_address <= cnt + ROW_BYTES + 13'd1;
                    end
                end
                FILL, CLEAR: begin
                    if ((state == FILL  && cnt == ROW_BYTES - 13'd1) ||
                        (state == CLEAR && cnt == ALL_BYTES - 13'd1)) begin
                        if (state == CLEAR) begin
                            cursor_x <= '0;
                            cursor_y <= '0;
                        end
                        state    <= IDLE;
                        mem_we   <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt         <= cnt + 13'd1;
                        mem_address <= mem_address + 13'd1;
                        // Even byte of a cell is the char, odd byte the attr.
                        wdata_q     <= cnt[0] ? BLANK : attr_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console with a behavioural 8 KB BRAM on its port.
module tb_text_console;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = '0;
    logic [7:0]  attr = '0;
    logic        in_ready;
    logic [7:0]  cursor_x, cursor_y;
    logic [12:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    text_console dut (
        .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .attr(attr), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [7:0] pal(input int i);
        return 8'(i * 13 + 1);
    endfunction

    logic [7:0]  mem [0:8191];
    logic        preload = 1'b0;
    int          we_cnt = 0;
    logic [12:0] max_addr = '0;

    always @(posedge CLOCK) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++)
                mem[i] <= (i < 4000) ? pat(i) : pal(i);
        end else if (mem_we) begin
            mem[mem_address] <= mem_wdata;
        end
        mem_rdata <= mem[mem_address];
    end

    always @(posedge CLOCK) begin
        if (!RESET) begin
            if (mem_we) we_cnt <= we_cnt + 1;
            if (mem_address > max_addr) max_addr <= mem_address;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 20000) begin
            @(negedge CLOCK);
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Returns at the falling edge right after the byte was accepted.
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        wait_ready();
        in_valid = 1'b1;
        in_char  = c;
        attr     = a;
        @(negedge CLOCK);
        in_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 10000) begin
            n++;
            @(negedge CLOCK);
        end
    endtask

    initial begin
        int n, err, perr, snap;

        repeat (3) @(negedge CLOCK);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cursor", 32'({cursor_x, cursor_y}), 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // 'A' with attr 0x1F: char write, attr write, then ready again
        send(8'h41, 8'h1F);
        check("a_char_cycle", 32'({in_ready, mem_we, mem_address, mem_wdata}),
              32'({1'b0, 1'b1, 13'd0, 8'h41}));
        @(negedge CLOCK);
        check("a_attr_cycle", 32'({in_ready, mem_we, mem_address, mem_wdata}),
              32'({1'b0, 1'b1, 13'd1, 8'h1F}));
        @(negedge CLOCK);
        check("a_ready_back", 32'({in_ready, mem_we}), 32'({1'b1, 1'b0}));
        check("a_mem", 32'({mem[0], mem[1]}), 32'h411F);
        check("a_cursor", 32'({cursor_x, cursor_y}), 32'({8'd1, 8'd0}));

        // Fill to column 79, then 'Z' wraps to next row
        for (int i = 0; i < 78; i++) send(8'h62, 8'h07);
        wait_ready();
        check("x79", 32'(cursor_x), 32'd79);
        send(8'h5A, 8'h07);
        wait_ready();
        check("z_mem", 32'({mem[158], mem[159]}), 32'h5A07);
        check("z_wrap", 32'({cursor_x, cursor_y}), 32'({8'd0, 8'd1}));

        for (int i = 0; i < 23; i++) send(8'h0A, 8'h07);
        wait_ready();
        check("lf_to_24", 32'({cursor_x, cursor_y}), 32'({8'd0, 8'd24}));

        // Scroll: LF on the last row
        @(negedge CLOCK);
        preload = 1'b1;
        @(negedge CLOCK);
        preload = 1'b0;
        send(8'h0A, 8'h2E);
        count_busy(n);
        check("scroll_busy_cycles", 32'(n), 32'd7840);
        wait_ready();
        err = 0;
        for (int i = 0; i < 3840; i++) if (mem[i] !== pat(i + 160)) err++;
        check("scroll_body", 32'(err), 32'd0);
        err = 0;
        for (int i = 3840; i < 4000; i++) if (mem[i] !== ((i % 2 == 0) ? 8'h20 : 8'h2E)) err++;
        check("scroll_fill", 32'(err), 32'd0);
        perr = 0;
        for (int i = 4000; i < 8192; i++) if (mem[i] !== pal(i)) perr++;
        check("scroll_palette", 32'(perr), 32'd0);
        check("scroll_cursor", 32'({cursor_x, cursor_y}), 32'({8'd0, 8'd24}));

        // BS at x=0 and an ignored control code: no writes, no movement
        send(8'h0D, 8'h07);
        snap = we_cnt;
        send(8'h08, 8'h5A);
        send(8'h01, 8'h5A);
        wait_ready();
        repeat (2) @(negedge CLOCK);
        check("bs0_no_write", 32'(we_cnt - snap), 32'd0);
        check("bs0_cursor", 32'({cursor_x, cursor_y}), 32'({8'd0, 8'd24}));

        for (int i = 0; i < 5; i++) send(8'h71, 8'h07);
        wait_ready();
        snap = we_cnt;
        send(8'h08, 8'h5A);
        wait_ready();
        check("bs_cursor", 32'({cursor_x, cursor_y}), 32'({8'd4, 8'd24}));
        check("bs_mem", 32'({mem[3848], mem[3849]}), 32'h205A);
        check("bs_writes", 32'(we_cnt - snap), 32'd2);

        // Form feed clears the screen
        send(8'h0C, 8'h4B);
        count_busy(n);
        check("clear_busy_cycles", 32'(n), 32'd4000);
        wait_ready();
        err = 0;
        for (int i = 0; i < 4000; i++) if (mem[i] !== ((i % 2 == 0) ? 8'h20 : 8'h4B)) err++;
        check("clear_body", 32'(err), 32'd0);
        perr = 0;
        for (int i = 4000; i < 8192; i++) if (mem[i] !== pal(i)) perr++;
        check("clear_palette", 32'(perr), 32'd0);
        check("clear_cursor", 32'({cursor_x, cursor_y}), 32'd0);

        // Reset in the middle of a scroll
        for (int i = 0; i < 25; i++) send(8'h0A, 8'h11);
        repeat (100) @(negedge CLOCK);
        check("midscroll_busy", 32'(busy), 32'd1);
        RESET = 1'b1;
        @(negedge CLOCK);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cursor", 32'({cursor_x, cursor_y}), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK);
        check("abort_ready_back", 32'(in_ready), 32'd1);

        check("addr_below_palette", 32'(max_addr < 13'hFA0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
